// File: rtl/median_pkg.sv
// Shared constants for the median-filter window sequencer: FSM encoding,
// border-handling modes and a ceil-log2 helper for sizing coordinate fields.
package median_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned BORDER_FLAG      = 0;
  localparam int unsigned BORDER_REPLICATE = 1;

  // Smallest r with 2^r >= v; used when deriving COORD_W/OFF_W at integration.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/win_offset_counter.sv
// Signed 2-D tap counter stepping (x,y) over -R..+R in raster order,
// wrapping to (-R,-R) after (+R,+R).
module win_offset_counter #(
  parameter int unsigned WIN   = 3,
  parameter int unsigned OFF_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  output logic signed [OFF_W-1:0] off_x_o,
  output logic signed [OFF_W-1:0] off_y_o,
  output logic                    first_c_o,
  output logic                    last_c_o
);

  localparam int unsigned R = (WIN - 1) / 2;
  localparam logic signed [OFF_W-1:0] POS_R = OFF_W'(R);
  localparam logic signed [OFF_W-1:0] NEG_R = -POS_R;
  localparam logic signed [OFF_W-1:0] ONE   = OFF_W'(1);

  logic signed [OFF_W-1:0] x_q, x_d;
  logic signed [OFF_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en_i) begin
      if (x_q == POS_R) begin
        x_d = NEG_R;
        y_d = (y_q == POS_R) ? NEG_R : y_q + ONE;
      end else begin
        x_d = x_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= NEG_R;
      y_q <= NEG_R;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign off_x_o   = x_q;
  assign off_y_o   = y_q;
  assign first_c_o = (x_q == NEG_R) && (y_q == NEG_R);
  assign last_c_o  = (x_q == POS_R) && (y_q == POS_R);

endmodule

// File: rtl/window_scan_ctrl.sv
// Frame-scan sequencer: walks every centre pixel in raster order and, per centre,
// every WIN x WIN tap, emitting border-resolved fetch coordinates under valid/ready.
module window_scan_ctrl
  import median_pkg::*;
#(
  parameter int unsigned WIN         = 3,
  parameter int unsigned IMG_W       = 640,
  parameter int unsigned IMG_H       = 480,
  parameter int unsigned BORDER_MODE = BORDER_REPLICATE,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned OFF_W       = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      ready,
  output logic                      valid,
  output logic signed [OFF_W-1:0]   offX,
  output logic signed [OFF_W-1:0]   offY,
  output logic [COORD_W-1:0]        centerX,
  output logic [COORD_W-1:0]        centerY,
  output logic [COORD_W-1:0]        addrX,
  output logic [COORD_W-1:0]        addrY,
  output logic                      oob,
  output logic                      winFirst,
  output logic                      winLast,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned SW = COORD_W + 2;
  localparam logic [COORD_W-1:0]   MAX_X = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0]   MAX_Y = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0]   ONE_C = COORD_W'(1);
  localparam logic signed [SW-1:0] LIM_X = SW'(IMG_W);
  localparam logic signed [SW-1:0] LIM_Y = SW'(IMG_H);

  logic [1:0]               state_q, state_d;
  logic [COORD_W-1:0]       cx_q, cx_d;
  logic [COORD_W-1:0]       cy_q, cy_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     adv;
  logic signed [OFF_W-1:0]  off_x, off_y;
  logic                     tap_first_c, tap_last_c;
  logic signed [SW-1:0]     raw_x, raw_y;
  logic                     oob_x, oob_y;
  logic [COORD_W-1:0]       addr_x, addr_y;

  win_offset_counter #(
    .WIN   (WIN),
    .OFF_W (OFF_W)
  ) u_off (
    .clk       (clk),
    .reset     (reset),
    .en_i      (adv),
    .off_x_o   (off_x),
    .off_y_o   (off_y),
    .first_c_o (tap_first_c),
    .last_c_o  (tap_last_c)
  );

  // Next state, centre raster counter and registered status flags.
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (ready) begin
          adv = 1'b1;
          if (tap_last_c) begin
            if (cx_q == MAX_X) begin
              cx_d = '0;
              if (cy_q == MAX_Y) begin
                cy_d    = '0;
                state_d = ST_DONE;
              end else begin
                cy_d = cy_q + ONE_C;
              end
            end else begin
              cx_d = cx_q + ONE_C;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_SCAN);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Fetch address straight from the registered counters; zeroed while no tap is live.
  always_comb begin
    raw_x  = $signed({2'b00, cx_q}) + SW'(off_x);
    raw_y  = $signed({2'b00, cy_q}) + SW'(off_y);
    oob_x  = raw_x[SW-1] || (raw_x >= LIM_X);
    oob_y  = raw_y[SW-1] || (raw_y >= LIM_Y);
    addr_x = raw_x[COORD_W-1:0];
    addr_y = raw_y[COORD_W-1:0];
    if (BORDER_MODE == BORDER_REPLICATE) begin
      if (raw_x[SW-1])    addr_x = '0;
      else if (oob_x)     addr_x = MAX_X;
      if (raw_y[SW-1])    addr_y = '0;
      else if (oob_y)     addr_y = MAX_Y;
    end
    if (!valid_q) begin
      addr_x = '0;
      addr_y = '0;
    end
  end

  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign offX     = off_x;
  assign offY     = off_y;
  assign centerX  = cx_q;
  assign centerY  = cy_q;
  assign addrX    = addr_x;
  assign addrY    = addr_y;
  assign oob      = valid_q && (oob_x || oob_y);
  assign winFirst = valid_q && tap_first_c;
  assign winLast  = valid_q && tap_last_c;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl: three instances cover replicate mode,
// flag-only mode and a 5x5 window on a tiny frame.
module tb_window_scan_ctrl;

  logic clk = 1'b0;
  logic reset, ready, start_a, start_b, start_c;
  always #5 clk = ~clk;

  logic              a_valid, a_oob, a_first, a_last, a_busy, a_done;
  logic signed [2:0] a_offX, a_offY;
  logic [9:0]        a_cx, a_cy, a_ax, a_ay;
  logic              b_valid, b_oob, b_first, b_last, b_busy, b_done;
  logic signed [2:0] b_offX, b_offY;
  logic [9:0]        b_cx, b_cy, b_ax, b_ay;
  logic              c_valid, c_oob, c_first, c_last, c_busy, c_done;
  logic signed [2:0] c_offX, c_offY;
  logic [9:0]        c_cx, c_cy, c_ax, c_ay;

  int tests = 0;
  int fails = 0;

  window_scan_ctrl #(.WIN(3), .IMG_W(4), .IMG_H(3), .BORDER_MODE(1), .COORD_W(10), .OFF_W(3)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .ready(ready), .valid(a_valid),
    .offX(a_offX), .offY(a_offY), .centerX(a_cx), .centerY(a_cy), .addrX(a_ax), .addrY(a_ay),
    .oob(a_oob), .winFirst(a_first), .winLast(a_last), .busy(a_busy), .done(a_done));

  window_scan_ctrl #(.WIN(3), .IMG_W(4), .IMG_H(3), .BORDER_MODE(0), .COORD_W(10), .OFF_W(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .ready(ready), .valid(b_valid),
    .offX(b_offX), .offY(b_offY), .centerX(b_cx), .centerY(b_cy), .addrX(b_ax), .addrY(b_ay),
    .oob(b_oob), .winFirst(b_first), .winLast(b_last), .busy(b_busy), .done(b_done));

  window_scan_ctrl #(.WIN(5), .IMG_W(3), .IMG_H(2), .BORDER_MODE(1), .COORD_W(10), .OFF_W(3)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .ready(ready), .valid(c_valid),
    .offX(c_offX), .offY(c_offY), .centerX(c_cx), .centerY(c_cy), .addrX(c_ax), .addrY(c_ay),
    .oob(c_oob), .winFirst(c_first), .winLast(c_last), .busy(c_busy), .done(c_done));

  // Expected outputs of tap k, derived from its index in the frame.
  task automatic model_tap(input int k, input int win, input int iw, input int ih,
                           input int bm, output logic [50:0] e);
    int r, t, c, ox, oy, cx, cy, rx, ry, ax, ay;
    logic o;
    r  = (win - 1) / 2;
    t  = k % (win * win);
    c  = k / (win * win);
    ox = (t % win) - r;
    oy = (t / win) - r;
    cx = c % iw;
    cy = c / iw;
    rx = cx + ox;
    ry = cy + oy;
    o  = (rx < 0) || (rx >= iw) || (ry < 0) || (ry >= ih);
    ax = rx;
    ay = ry;
    if (bm == 1) begin
      if (ax < 0) ax = 0;
      if (ax >= iw) ax = iw - 1;
      if (ay < 0) ay = 0;
      if (ay >= ih) ay = ih - 1;
    end
    e = {3'(ox), 3'(oy), 10'(cx), 10'(cy), 10'(ax), 10'(ay), o, (t == 0), (t == win * win - 1), 1'b1, 1'b0};
  endtask

  // Full scan on dut_a with optional back-pressure, mid-scan start and abort.
  task automatic scan_a(input bit rand_ready, input int restart_at, input int reset_at, output int taps);
    int k, cyc;
    bit r, restarted;
    logic [50:0] e, act;
    k = 0; cyc = 0; restarted = 0;
    @(negedge clk); start_a = 1'b1; ready = 1'b1;
    @(negedge clk); start_a = 1'b0;
    tests++;
    if ({a_valid, a_busy} !== 2'b11) begin
      fails++; $display("FAIL first_valid: valid/busy=%b%b expected 11", a_valid, a_busy);
    end
    while (k < 108 && cyc < 4000) begin
      model_tap(k, 3, 4, 3, 1, e);
      act = {a_offX, a_offY, a_cx, a_cy, a_ax, a_ay, a_oob, a_first, a_last, a_valid, a_done};
      tests++;
      if (act !== e) begin
        fails++; $display("FAIL tap%0d: got %h expected %h", k, act, e);
      end
      if (k == 0) begin
        tests++;
        if ({a_oob, a_ax, a_ay} !== {1'b1, 10'd0, 10'd0}) begin
          fails++; $display("FAIL corner_tl: oob=%b addr=(%0d,%0d) expected 1 (0,0)", a_oob, a_ax, a_ay);
        end
      end
      if (k == 107) begin
        tests++;
        if ({a_oob, a_ax, a_ay, a_offX, a_offY} !== {1'b1, 10'd3, 10'd2, 3'b001, 3'b001}) begin
          fails++; $display("FAIL corner_br: oob=%b addr=(%0d,%0d) off=(%0d,%0d) expected 1 (3,2) (1,1)",
                            a_oob, a_ax, a_ay, a_offX, a_offY);
        end
      end
      start_a = (k == restart_at) && !restarted;
      if (start_a) restarted = 1'b1;
      if (k == reset_at) begin
        start_a = 1'b0; reset = 1'b1; ready = 1'b1;
        @(negedge clk); reset = 1'b0;
        tests++;
        if ({a_valid, a_busy, a_done} !== 3'b000) begin
          fails++; $display("FAIL abort_flags: valid/busy/done=%b%b%b expected 000", a_valid, a_busy, a_done);
        end
        tests++;
        if ({a_offX, a_offY, a_cx, a_cy} !== {3'b111, 3'b111, 10'd0, 10'd0}) begin
          fails++; $display("FAIL abort_counters: off=(%0d,%0d) c=(%0d,%0d) expected (-1,-1) (0,0)",
                            a_offX, a_offY, a_cx, a_cy);
        end
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          tests++;
          if (a_done !== 1'b0) begin
            fails++; $display("FAIL abort_no_done: done=%b expected 0", a_done);
          end
        end
        taps = k;
        return;
      end
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      ready = r;
      @(negedge clk);
      cyc++;
      if (r) k++;
    end
    start_a = 1'b0; ready = 1'b1; taps = k;
    tests++;
    if ({a_valid, a_done, a_busy} !== 3'b011) begin
      fails++; $display("FAIL done_pulse: valid/done/busy=%b%b%b expected 011", a_valid, a_done, a_busy);
    end
    @(negedge clk);
    tests++;
    if ({a_valid, a_done, a_busy} !== 3'b000) begin
      fails++; $display("FAIL after_done: valid/done/busy=%b%b%b expected 000", a_valid, a_done, a_busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; ready = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({a_valid, a_busy, a_done, a_first, a_last, a_oob} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: v/b/d/f/l/o=%b%b%b%b%b%b expected 000000",
                        a_valid, a_busy, a_done, a_first, a_last, a_oob);
    end
    tests++;
    if ({a_offX, a_offY} !== {3'b111, 3'b111}) begin
      fails++; $display("FAIL reset_offsets: (%0d,%0d) expected (-1,-1)", a_offX, a_offY);
    end
    tests++;
    if ({a_cx, a_cy, a_ax, a_ay} !== 40'd0) begin
      fails++; $display("FAIL reset_coords: c=(%0d,%0d) a=(%0d,%0d) expected zeros", a_cx, a_cy, a_ax, a_ay);
    end
  endtask

  task automatic test_start_vs_reset;
    @(negedge clk); reset = 1'b1; start_a = 1'b1;
    @(negedge clk); reset = 1'b0; start_a = 1'b0;
    tests++;
    if ({a_valid, a_busy} !== 2'b00) begin
      fails++; $display("FAIL start_with_reset: valid/busy=%b%b expected 00", a_valid, a_busy);
    end
  endtask

  task automatic test_scan(input bit rand_ready, input int restart_at, input string name);
    int n;
    scan_a(rand_ready, restart_at, -1, n);
    tests++;
    if (n !== 108) begin
      fails++; $display("FAIL %s_count: taps=%0d expected 108", name, n);
    end
  endtask

  task automatic test_reset_abort;
    int n;
    scan_a(1'b1, -1, 50, n);
    tests++;
    if (n !== 50) begin
      fails++; $display("FAIL abort_point: taps=%0d expected 50", n);
    end
  endtask

  task automatic test_flag_mode;
    int cyc;
    ready = 1'b1;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    tests++;
    if ({b_oob, b_ax, b_ay} !== {1'b1, 10'd1023, 10'd1023}) begin
      fails++; $display("FAIL flag_tap0: oob=%b addr=(%0d,%0d) expected 1 (1023,1023)", b_oob, b_ax, b_ay);
    end
    repeat (3) @(negedge clk);
    tests++;
    if ({b_offX, b_offY, b_cx, b_cy, b_oob, b_ax, b_ay} !==
        {3'b111, 3'b000, 10'd0, 10'd0, 1'b1, 10'd1023, 10'd0}) begin
      fails++; $display("FAIL flag_tap3: off=(%0d,%0d) c=(%0d,%0d) oob=%b addr=(%0d,%0d) expected (-1,0) (0,0) 1 (1023,0)",
                        b_offX, b_offY, b_cx, b_cy, b_oob, b_ax, b_ay);
    end
    @(negedge clk);
    tests++;
    if ({b_oob, b_ax, b_ay} !== {1'b0, 10'd0, 10'd0}) begin
      fails++; $display("FAIL flag_tap4: oob=%b addr=(%0d,%0d) expected 0 (0,0)", b_oob, b_ax, b_ay);
    end
    cyc = 0;
    while (b_done !== 1'b1 && cyc < 300) begin
      @(negedge clk); cyc++;
    end
    tests++;
    if (b_done !== 1'b1) begin
      fails++; $display("FAIL flag_done: done=%b expected 1 within budget", b_done);
    end
    @(negedge clk);
  endtask

  task automatic test_win5;
    int n, nf, nl, cyc, mnx, mxx, mny, mxy;
    n = 0; nf = 0; nl = 0; cyc = 0; mnx = 99; mxx = -99; mny = 99; mxy = -99;
    ready = 1'b1;
    @(negedge clk); start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
    while (c_done !== 1'b1 && cyc < 1000) begin
      if (c_valid) begin
        n++;
        nf += int'(c_first);
        nl += int'(c_last);
        if (int'(c_offX) < mnx) mnx = int'(c_offX);
        if (int'(c_offX) > mxx) mxx = int'(c_offX);
        if (int'(c_offY) < mny) mny = int'(c_offY);
        if (int'(c_offY) > mxy) mxy = int'(c_offY);
      end
      @(negedge clk); cyc++;
    end
    tests++;
    if (n !== 150) begin
      fails++; $display("FAIL win5_count: taps=%0d expected 150", n);
    end
    tests++;
    if (nf !== 6 || nl !== 6) begin
      fails++; $display("FAIL win5_markers: first=%0d last=%0d expected 6 6", nf, nl);
    end
    tests++;
    if (mnx !== -2 || mxx !== 2 || mny !== -2 || mxy !== 2) begin
      fails++; $display("FAIL win5_span: x %0d..%0d y %0d..%0d expected -2..2", mnx, mxx, mny, mxy);
    end
    @(negedge clk);
    tests++;
    if ({c_busy, c_done} !== 2'b00) begin
      fails++; $display("FAIL win5_idle: busy/done=%b%b expected 00", c_busy, c_done);
    end
  endtask

  initial begin
    test_reset();
    test_start_vs_reset();
    test_scan(1'b0, -1, "full");
    test_scan(1'b1, 20, "backpressure");
    test_reset_abort();
    test_scan(1'b0, -1, "restart");
    test_flag_mode();
    test_win5();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
